// File: rtl/lifo_sa.sv
// LIFO stack: one inferred RAM plus a word count, optional top-of-stack show-ahead.
// Define LIFO_SA_ERR_FLAGS_EN to add the sticky overflow/underflow flags and clr_err_i.
module lifo_sa #(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 8,
  parameter int ALMOST_FULL  = 2,
  parameter int ALMOST_EMPTY = 2,
  parameter int SHOWAHEAD    = 0
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              almost_empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic [AWIDTH:0]   usedw_o
`ifdef LIFO_SA_ERR_FLAGS_EN
  ,
  input  logic              clr_err_i,
  output logic              ovf_o,
  output logic              udf_o
`endif
);

  localparam int DEPTH = 2**AWIDTH;
  localparam int AW1   = AWIDTH + 1;
  localparam logic [AWIDTH:0]   DEPTH_W = AW1'(DEPTH);
  localparam logic [AWIDTH:0]   AF_LVL  = AW1'(ALMOST_FULL);
  localparam logic [AWIDTH:0]   AE_LVL  = AW1'(ALMOST_EMPTY);
  localparam logic [AWIDTH:0]   ONE_W   = AW1'(1);
  localparam logic [AWIDTH-1:0] ONE_A   = AWIDTH'(1);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic [DWIDTH-1:0] q_q, q_d;
  logic              empty_q, almost_empty_q, full_q, almost_full_q;
  logic              push_ok, pop_ok;
  logic [AWIDTH-1:0] wr_addr, top_addr;

  assign push_ok  = wrreq_i & ~full_q;
  assign pop_ok   = rdreq_i & ~empty_q;
  // usedw_q is also the next free slot; at DEPTH it wraps to 0, but no push happens then.
  assign wr_addr  = usedw_q[AWIDTH-1:0];
  assign top_addr = wr_addr - ONE_A;

  always_comb begin
    usedw_d = usedw_q;
    if (push_ok && !pop_ok) begin
      usedw_d = usedw_q + ONE_W;
    end else if (pop_ok && !push_ok) begin
      usedw_d = usedw_q - ONE_W;
    end
  end

  always_comb begin
    q_d = q_q;
    if (SHOWAHEAD == 0) begin
      if (push_ok && pop_ok) begin
        q_d = data_i;
      end else if (pop_ok) begin
        q_d = mem_q[top_addr];
      end
    end else begin
      // q_o mirrors the top of stack; a push+pop pair leaves the top untouched.
      if (push_ok && !pop_ok) begin
        q_d = data_i;
      end else if (pop_ok && !push_ok) begin
        q_d = (usedw_q == ONE_W) ? '0 : mem_q[top_addr - ONE_A];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !pop_ok) begin
      mem_q[wr_addr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      usedw_q        <= '0;
      q_q            <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      full_q         <= 1'b0;
      almost_full_q  <= (AF_LVL == '0);
    end else begin
      usedw_q        <= usedw_d;
      q_q            <= q_d;
      empty_q        <= (usedw_d == '0);
      almost_empty_q <= (usedw_d <= AE_LVL);
      full_q         <= (usedw_d == DEPTH_W);
      almost_full_q  <= (usedw_d >= AF_LVL);
    end
  end

  assign q_o            = q_q;
  assign usedw_o        = usedw_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = almost_empty_q;
  assign full_o         = full_q;
  assign almost_full_o  = almost_full_q;

`ifdef LIFO_SA_ERR_FLAGS_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // A new error in the same cycle as clr_err_i stays visible.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_err_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wrreq_i && full_q && !pop_ok) begin
      ovf_d = 1'b1;
    end
    if (rdreq_i && empty_q) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

endmodule

// File: tb/tb_lifo_sa.sv
// Scoreboard bench: a registered-read 256-deep stack and an 8-deep show-ahead stack share stimulus.
module tb_lifo_sa;

  localparam int DW    = 16;
  localparam int AF_A  = 2;
  localparam int AE_A  = 2;
  localparam int AF_B  = 6;
  localparam int AE_B  = 1;
  localparam int DEP_A = 256;
  localparam int DEP_B = 8;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] data = '0;

  logic [DW-1:0] q_a, q_b;
  logic [8:0]    usedw_a;
  logic [3:0]    usedw_b;
  logic          empty_a, aempty_a, full_a, afull_a;
  logic          empty_b, aempty_b, full_b, afull_b;
  logic          ovf_a, udf_a, ovf_b, udf_b;

  always #5 clk = ~clk;

  lifo_sa #(.DWIDTH(DW), .AWIDTH(8), .ALMOST_FULL(AF_A), .ALMOST_EMPTY(AE_A), .SHOWAHEAD(0)) dut_a (
    .clk_i(clk), .srst_i(srst), .wrreq_i(wrreq), .data_i(data), .rdreq_i(rdreq),
    .q_o(q_a), .empty_o(empty_a), .almost_empty_o(aempty_a), .full_o(full_a),
    .almost_full_o(afull_a), .usedw_o(usedw_a)
`ifdef LIFO_SA_ERR_FLAGS_EN
    , .clr_err_i(clr_err), .ovf_o(ovf_a), .udf_o(udf_a)
`endif
  );

  lifo_sa #(.DWIDTH(DW), .AWIDTH(3), .ALMOST_FULL(AF_B), .ALMOST_EMPTY(AE_B), .SHOWAHEAD(1)) dut_b (
    .clk_i(clk), .srst_i(srst), .wrreq_i(wrreq), .data_i(data), .rdreq_i(rdreq),
    .q_o(q_b), .empty_o(empty_b), .almost_empty_o(aempty_b), .full_o(full_b),
    .almost_full_o(afull_b), .usedw_o(usedw_b)
`ifdef LIFO_SA_ERR_FLAGS_EN
    , .clr_err_i(clr_err), .ovf_o(ovf_b), .udf_o(udf_b)
`endif
  );

`ifndef LIFO_SA_ERR_FLAGS_EN
  assign ovf_a = 1'b0;
  assign udf_a = 1'b0;
  assign ovf_b = 1'b0;
  assign udf_b = 1'b0;
`endif

  typedef struct {
    int            cnt_a;
    logic [DW-1:0] q_a;
    logic          ovf_a;
    logic          udf_a;
    int            cnt_b;
    logic [DW-1:0] q_b;
    logic          ovf_b;
    logic          udf_b;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: an array used as a stack plus a word count per instance.
  logic [DW-1:0] mstk [2][256];
  int            mcnt [2];
  logic [DW-1:0] mq   [2];
  logic          movf [2];
  logic          mudf [2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model(input int k, input int dep, input bit sa,
                       input logic wr, input logic rd, input logic [DW-1:0] d,
                       input logic rst, input logic clr);
    bit vpush, vpop, set_o, set_u;
    if (rst) begin
      mcnt[k] = 0;
      mq[k]   = '0;
      movf[k] = 1'b0;
      mudf[k] = 1'b0;
    end else begin
      vpush = wr && (mcnt[k] < dep);
      vpop  = rd && (mcnt[k] > 0);
      set_o = wr && (mcnt[k] == dep) && !vpop;
      set_u = rd && (mcnt[k] == 0);
      movf[k] = set_o ? 1'b1 : (clr ? 1'b0 : movf[k]);
      mudf[k] = set_u ? 1'b1 : (clr ? 1'b0 : mudf[k]);
      if (vpush && vpop) begin
        if (!sa) mq[k] = d;
      end else if (vpush) begin
        mstk[k][mcnt[k]] = d;
        mcnt[k]++;
      end else if (vpop) begin
        mcnt[k]--;
        if (!sa) mq[k] = mstk[k][mcnt[k]];
      end
      if (sa) mq[k] = (mcnt[k] > 0) ? mstk[k][mcnt[k]-1] : '0;
    end
  endtask

  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d,
                      input logic rst, input logic clr);
    exp_t e;
    @(negedge clk);
    wrreq   = wr;
    rdreq   = rd;
    data    = d;
    srst    = rst;
    clr_err = clr;
    model(0, DEP_A, 1'b0, wr, rd, d, rst, clr);
    model(1, DEP_B, 1'b1, wr, rd, d, rst, clr);
    e.cnt_a = mcnt[0]; e.q_a = mq[0]; e.ovf_a = movf[0]; e.udf_a = mudf[0];
    e.cnt_b = mcnt[1]; e.q_b = mq[1]; e.ovf_b = movf[1]; e.udf_b = mudf[1];
    exp_q.push_back(e);
  endtask

  // Monitor: each edge the DUTs present a new state; compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_usedw",  32'(usedw_a),  32'(e.cnt_a));
        chk("a_q",      32'(q_a),      32'(e.q_a));
        chk("a_empty",  32'(empty_a),  32'(e.cnt_a == 0));
        chk("a_aempty", 32'(aempty_a), 32'(e.cnt_a <= AE_A));
        chk("a_full",   32'(full_a),   32'(e.cnt_a == DEP_A));
        chk("a_afull",  32'(afull_a),  32'(e.cnt_a >= AF_A));
        chk("b_usedw",  32'(usedw_b),  32'(e.cnt_b));
        chk("b_q",      32'(q_b),      32'(e.q_b));
        chk("b_empty",  32'(empty_b),  32'(e.cnt_b == 0));
        chk("b_aempty", 32'(aempty_b), 32'(e.cnt_b <= AE_B));
        chk("b_full",   32'(full_b),   32'(e.cnt_b == DEP_B));
        chk("b_afull",  32'(afull_b),  32'(e.cnt_b >= AF_B));
`ifdef LIFO_SA_ERR_FLAGS_EN
        chk("a_ovf", 32'(ovf_a), 32'(e.ovf_a));
        chk("a_udf", 32'(udf_a), 32'(e.udf_a));
        chk("b_ovf", 32'(ovf_b), 32'(e.ovf_b));
        chk("b_udf", 32'(udf_b), 32'(e.udf_b));
`endif
      end
    end
  end

  initial begin
    int p_wr, p_rd;
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    // Pops from empty, then clear the underflow.
    for (int i = 0; i < 32; i++) step(0, 1, DW'($urandom), 0, 0);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);
    // Overfill, then over-drain.
    for (int i = 0; i < 261; i++) step(1, 0, DW'($urandom), 0, 0);
    for (int i = 0; i < 258; i++) step(0, 1, DW'($urandom), 0, 0);
    step(0, 0, '0, 0, 1);
    // Push 5, long push+pop overlap, drain 5.
    for (int i = 0; i < 5; i++)   step(1, 0, DW'($urandom), 0, 0);
    for (int i = 0; i < 251; i++) step(1, 1, DW'($urandom), 0, 0);
    for (int i = 0; i < 5; i++)   step(0, 1, DW'($urandom), 0, 0);
    // Reset mid-stream with a push pending.
    for (int i = 0; i < 3; i++)   step(1, 0, DW'($urandom), 0, 0);
    step(1, 0, DW'($urandom), 1, 0);
    step(0, 0, '0, 0, 0);
    // Random traffic with shifting push/pop bias.
    for (int blk = 0; blk < 10; blk++) begin
      p_wr = $urandom_range(10, 90);
      p_rd = $urandom_range(10, 90);
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 99) < p_wr), ($urandom_range(0, 99) < p_rd), DW'($urandom),
             ($urandom_range(0, 299) == 0), ($urandom_range(0, 29) == 0));
      end
    end
    step(0, 0, '0, 0, 0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lifo_sa.md
LIFO_SA -- requirements
Module: lifo_sa

Interface
REQ-001 Parameter DWIDTH, default 16, data word width in bits.
REQ-002 Parameter AWIDTH, default 8, address width; depth = 2**AWIDTH words.
REQ-003 Parameter ALMOST_FULL, default 2, almost_full_o threshold (words).
REQ-004 Parameter ALMOST_EMPTY, default 2, almost_empty_o threshold (words).
REQ-005 Parameter SHOWAHEAD, default 0; 0 = registered read, 1 = top-of-stack show-ahead.
REQ-006 Ports SHALL be, one clock, reset synchronous and active-high:
 clk_i  in  1  clock;
 srst_i  in  1  synchronous active-high reset;
 wrreq_i  in  1  push request;
 data_i  in  DWIDTH  push data;
 rdreq_i  in  1  pop request;
 q_o  out  DWIDTH  read data;
 empty_o  out  1  usedw_o == 0;
 almost_empty_o  out  1  usedw_o <= ALMOST_EMPTY;
 full_o  out  1  usedw_o == 2**AWIDTH;
 almost_full_o  out  1  usedw_o >= ALMOST_FULL;
 usedw_o  out  AWIDTH+1  stored word count;
 clr_err_i  in  1  clear error flags (macro only);
 ovf_o  out  1  sticky overflow (macro only);
 udf_o  out  1  sticky underflow (macro only).

Function
REQ-007 Valid push = wrreq_i & !full_o; valid pop = rdreq_i & !empty_o; both evaluated on registered status at the rising edge.
REQ-008 Push only: data_i stored on top, usedw_o +1 next cycle.
REQ-009 Pop only: top word removed, usedw_o -1 next cycle.
REQ-010 Push and pop both valid (stack non-empty, not full): stack contents and usedw_o unchanged; the popped word is data_i (push-then-pop).
REQ-011 Both requested while empty: push only, read ignored, q_o unchanged (SHOWAHEAD=0).
REQ-012 Both requested while full: pop only, write ignored, usedw_o -1.
REQ-013 Push while full and pop while empty SHALL leave stack, usedw_o and q_o unchanged.
REQ-014 SHOWAHEAD=0: q_o = popped word one cycle after valid pop edge; q_o holds its value otherwise.
REQ-015 SHOWAHEAD=1: after every edge q_o equals current top-of-stack (most recent unpopped word), or 0 when empty; rdreq_i acknowledges/removes it; zero-latency view, no extra cycle.
REQ-016 All status flags SHALL be registered and consistent with usedw_o in the same cycle.
REQ-017 usedw_o width AWIDTH+1 SHALL represent 0..2**AWIDTH exactly; no wrap-around.
REQ-018 Storage SHALL be one inferred RAM of 2**AWIDTH x DWIDTH plus pointer logic; no per-word registers.

Reset
REQ-019 srst_i high at an edge: usedw_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=(ALMOST_FULL==0), q_o=0, ovf_o=0, udf_o=0.
REQ-020 srst_i SHALL override simultaneous wrreq_i/rdreq_i; reset mid-operation discards all contents; RAM contents need not be cleared.

Configuration
REQ-021 Macro LIFO_SA_ERR_FLAGS_EN defined: ports clr_err_i, ovf_o, udf_o present; ovf_o set on wrreq_i while full_o without valid pop; udf_o set on rdreq_i while empty_o; both sticky until clr_err_i or srst_i; set wins over clr_err_i in the same cycle.
REQ-022 Macro undefined: those three ports and their logic absent; all other behaviour identical.

Verification (AWIDTH=8, ALMOST_FULL=2, ALMOST_EMPTY=2)
REQ-023 261 consecutive pushes from reset -> usedw_o saturates 256, full_o=1 after 256th, last 5 words dropped, ovf_o=1 (macro on).
REQ-024 Fill 256 then 258 pops, SHOWAHEAD=0 -> q_o returns words in reverse push order, each one cycle after its pop; empty_o=1 after 256th; udf_o=1; q_o holds last word.
REQ-025 Push 5 words, then 251 cycles push+pop, then 5 pops -> usedw_o stays 5 during overlap, each overlap q_o = that cycle's data_i, final 5 pops return first 5 words reversed.
REQ-026 32 pops from reset -> usedw_o=0, empty_o=1, q_o=0 throughout, udf_o=1; clr_err_i pulse -> udf_o=0.
REQ-027 SHOWAHEAD=1: push A,B,C -> q_o=A,B,C after each edge; pop -> q_o=B; pop,pop -> q_o=0, empty_o=1.
REQ-028 Push 3 words then srst_i mid-stream with wrreq_i=1 -> next cycle usedw_o=0, empty_o=1, q_o=0; almost flags toggle at usedw_o 2->3 and 1->2 exactly.
